// File: rtl/dac_interface.sv
// dac_interface
//   Transmit path toward an external 16-bit SPI DAC. Signed samples arrive on
//   a valid/ready handshake and queue in a small FIFO. Once per sample period
//   the head sample is popped, converted to offset binary and shifted out MSB
//   first on an SPI mode-0 link (SCLK idle low, data stable on rising edge).
//
//   Optional build macro: DAC_UNDERRUN_ZERO_EN
//     defined   - an empty-FIFO sample period transmits midscale (sample 0)
//     undefined - an empty-FIFO sample period repeats the last sample
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   s_data        signed sample, s_valid qualifies it, s_ready = FIFO not full
//   underrun_clr  clears the sticky underrun flag
//   dac_cs_n      DAC chip select (active low)
//   dac_sclk      SPI clock
//   dac_mosi      SPI data, MSB first
//   frame_done    one-cycle pulse as a frame finishes
//   underrun      sticky, set when a sample period found the FIFO empty
//   fifo_level    FIFO occupancy 0..FIFO_DEPTH
module dac_interface #(
    parameter int CLK_DIV    = 100,
    parameter int SCLK_DIV   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          underrun_clr,
    output logic                          dac_cs_n,
    output logic                          dac_sclk,
    output logic                          dac_mosi,
    output logic                          frame_done,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    // Half-period counter needs at least one bit even when SCLK_DIV is 1.
    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   level_reg, level_next;
    logic [CW-1:0] tick_cnt_reg;
    logic [15:0]   last_reg, sample_next;
    logic          underrun_reg;

    state_t        state_reg, state_next;
    logic          cs_n_reg, cs_n_next;
    logic          sclk_reg, sclk_next;
    logic          mosi_reg, mosi_next;
    logic          done_reg, done_next;
    logic [15:0]   shift_reg, shift_next;
    logic [DW-1:0] div_reg, div_next;
    logic [4:0]    edge_reg, edge_next;

    logic tick, empty, push, pop;
    logic [15:0] code;

    assign tick    = (tick_cnt_reg == CW'(CLK_DIV - 1));
    assign empty   = (level_reg == '0);
    assign s_ready = (level_reg != (AW+1)'(FIFO_DEPTH));
    assign push    = s_valid && s_ready;
    // Empty is judged on the registered level, so a push landing in the tick
    // cycle is too late for that period.
    assign pop     = tick && !empty;

    // Sample for this period: FIFO head, otherwise the underrun policy.
    always_comb begin
        sample_next = last_reg;
        if (pop) begin
            sample_next = mem[rd_ptr_reg];
        end
`ifdef DAC_UNDERRUN_ZERO_EN
        else if (tick) begin
            sample_next = '0;
        end
`endif
    end

    // Two's complement to offset binary is just an MSB flip.
    assign code = sample_next ^ 16'h8000;

    always_comb begin
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // Storage carries no reset; flushing is done through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            tick_cnt_reg <= '0;
            last_reg     <= '0;
            underrun_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg    <= level_next;
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick) last_reg <= sample_next;
            // A new empty tick beats a simultaneous clear.
            if (tick && empty)     underrun_reg <= 1'b1;
            else if (underrun_clr) underrun_reg <= 1'b0;
        end
    end

    // Serializer next-state and outputs. Toggles are numbered 0..31 in
    // edge_reg; odd ones are falling edges, and the final falling edge
    // closes the frame instead of advancing MOSI.
    always_comb begin
        state_next = state_reg;
        cs_n_next  = cs_n_reg;
        sclk_next  = sclk_reg;
        mosi_next  = mosi_reg;
        done_next  = 1'b0;
        shift_next = shift_reg;
        div_next   = div_reg;
        edge_next  = edge_reg;
        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next = SHIFT;
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b0;
                    shift_next = code;
                    mosi_next  = code[15];
                    div_next   = '0;
                    edge_next  = '0;
                end
            end
            SHIFT: begin
                if (div_reg == DW'(SCLK_DIV - 1)) begin
                    div_next  = '0;
                    edge_next = edge_reg + 5'd1;
                    sclk_next = ~sclk_reg;
                    if (sclk_reg) begin
                        if (edge_reg == 5'd31) begin
                            state_next = IDLE;
                            cs_n_next  = 1'b1;
                            sclk_next  = 1'b0;
                            mosi_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            shift_next = {shift_reg[14:0], 1'b0};
                            mosi_next  = shift_reg[14];
                        end
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cs_n_reg  <= 1'b1;
            sclk_reg  <= 1'b0;
            mosi_reg  <= 1'b0;
            done_reg  <= 1'b0;
            shift_reg <= '0;
            div_reg   <= '0;
            edge_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cs_n_reg  <= cs_n_next;
            sclk_reg  <= sclk_next;
            mosi_reg  <= mosi_next;
            done_reg  <= done_next;
            shift_reg <= shift_next;
            div_reg   <= div_next;
            edge_reg  <= edge_next;
        end
    end

    assign dac_cs_n   = cs_n_reg;
    assign dac_sclk   = sclk_reg;
    assign dac_mosi   = mosi_reg;
    assign frame_done = done_reg;
    assign underrun   = underrun_reg;
    assign fifo_level = level_reg;

endmodule

// File: tb/tb_dac_interface.sv
`timescale 1ns/1ps
// Bench for dac_interface: table of sample->code vectors, hand sequences for
// reset, fill, underrun and mid-frame reset, then randomized traffic checked
// against a queue-based reference model and an SPI frame decoder.
module tb_dac_interface;
    localparam int CLK_DIV  = 100;
    localparam int SCLK_DIV = 2;
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        s_ready, dac_cs_n, dac_sclk, dac_mosi, frame_done, underrun;
    logic [$clog2(DEPTH):0] fifo_level;

    dac_interface #(.CLK_DIV(CLK_DIV), .SCLK_DIV(SCLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .underrun_clr(underrun_clr), .dac_cs_n(dac_cs_n),
        .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .frame_done(frame_done),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] code; int fall; } exp_t;
    exp_t        exp_q[$];
    exp_t        exp_tmp;
    logic [15:0] m_q[$];
    logic [15:0] m_last = '0;
    logic        m_under = 1'b0;
    int          m_k = 0;
    int          cyc = 0;
    bit          m_full_pre, m_uset;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            exp_q.delete();
            m_last  = '0;
            m_under = 1'b0;
            m_k     = 0;
        end else begin
            cyc++;
            m_k++;
            m_full_pre = (m_q.size() == DEPTH);
            m_uset     = 1'b0;
            if (m_k % CLK_DIV == 0) begin
                if (m_q.size() > 0) begin
                    m_last = m_q.pop_front();
                end else begin
                    m_uset = 1'b1;
`ifdef DAC_UNDERRUN_ZERO_EN
                    m_last = '0;
`endif
                end
                exp_tmp.code = m_last ^ 16'h8000;
                exp_tmp.fall = cyc;
                exp_q.push_back(exp_tmp);
            end
            if (s_valid && !m_full_pre) m_q.push_back(s_data);
            if (m_uset) m_under = 1'b1;
            else if (underrun_clr) m_under = 1'b0;
        end
    end

    // ---------------- SPI decoder / per-cycle checks ----------------
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, mon_active = 1'b0;
    logic [15:0] mon_bits = '0;
    int          mon_nbits = 0, mon_low = 0;
    logic [15:0] frames_q[$];
    int          falls_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
            prev_cs    = 1'b1;
            prev_sclk  = 1'b0;
            mon_nbits  = 0;
        end else begin
            chk("fifo_level", fifo_level, m_q.size());
            chk("s_ready", s_ready, m_q.size() < DEPTH);
            chk("underrun", underrun, m_under);
            if (prev_cs && !dac_cs_n) begin
                mon_active = 1'b1;
                mon_nbits  = 0;
                mon_low    = 0;
                mon_bits   = '0;
                falls_q.push_back(cyc);
                if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                else chk("cs_fall_cycle", cyc, exp_q[0].fall);
            end
            if (!dac_cs_n) mon_low++;
            if (!dac_cs_n && !prev_sclk && dac_sclk) begin
                mon_bits = {mon_bits[14:0], dac_mosi};
                mon_nbits++;
            end
            if (!prev_cs && dac_cs_n && mon_active) begin
                chk("frame_done_pulse", frame_done, 1);
                chk("frame_bits", mon_nbits, 16);
                chk("cs_low_cycles", mon_low, 32 * SCLK_DIV);
                if (exp_q.size() == 0) chk("frame_expected", 0, 1);
                else begin
                    chk("frame_data", mon_bits, exp_q[0].code);
                    void'(exp_q.pop_front());
                end
                frames_q.push_back(mon_bits);
                mon_active = 1'b0;
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            if (dac_cs_n) begin
                chk("idle_sclk", dac_sclk, 0);
                chk("idle_mosi", dac_mosi, 0);
            end
            prev_cs   = dac_cs_n;
            prev_sclk = dac_sclk;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] frame_at(input int i);
        if (i < frames_q.size()) return frames_q[i];
        return 16'hxxxx;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        s_valid = 1'b0;
        underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        frames_q.delete();
        falls_q.delete();
    endtask

    task automatic push(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (frames_q.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("wait_frames", frames_q.size() >= n, 1);
    endtask

    typedef struct { logic [15:0] sample; logic [15:0] code; } vec_t;
    vec_t vecs[6];
    int   rates[4];
    int   acc;
    int   c;

    initial begin
        vecs[0] = '{16'h8000, 16'h0000};
        vecs[1] = '{16'h7FFF, 16'hFFFF};
        vecs[2] = '{16'h1234, 16'h9234};
        vecs[3] = '{16'h0100, 16'h8100};
        vecs[4] = '{16'h0000, 16'h8000};
        vecs[5] = '{16'hFFFF, 16'h7FFF};
        rates   = '{4, 10, 40, 200};

        // Reset state, observed while reset is held.
        @(negedge clk);
        #1;
        chk("rst_cs_n", dac_cs_n, 1);
        chk("rst_sclk", dac_sclk, 0);
        chk("rst_mosi", dac_mosi, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_s_ready", s_ready, 1);

        // Single sample ahead of the first tick.
        do_reset();
        push(16'h1234);
        chk("t1_level_before", fifo_level, 1);
        wait_frames(1, 300);
        chk("t1_frame", frame_at(0), 16'h9234);
        chk("t1_level_after", fifo_level, 0);

        // Vector table, pushed back to back, drained one per period.
        do_reset();
        foreach (vecs[i]) push(vecs[i].sample);
        wait_frames(6, 800);
        for (int i = 0; i < 6; i++)
            chk($sformatf("vec%0d_code", i), frame_at(i), vecs[i].code);
        chk("vec_spacing", (falls_q.size() > 1) ? falls_q[1] - falls_q[0] : -1, CLK_DIV);
        chk("vec_underrun", underrun, 0);

        // Valid held high from reset: fill, then one accept per period.
        do_reset();
        s_valid = 1'b1;
        s_data  = $urandom;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            s_data = $urandom;
        end
        chk("t3_full_level", fifo_level, DEPTH);
        chk("t3_full_ready", s_ready, 0);
        acc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (s_ready) acc++;
            s_data = $urandom;
        end
        chk("t3_accepts", acc, 4);
        s_valid = 1'b0;

        // Underrun policy and sticky flag clear.
        do_reset();
        push(16'h0100);
        wait_frames(1, 300);
        chk("t4_frame1", frame_at(0), 16'h8100);
        chk("t4_no_underrun", underrun, 0);
        wait_frames(2, 300);
`ifdef DAC_UNDERRUN_ZERO_EN
        chk("t4_frame2", frame_at(1), 16'h8000);
`else
        chk("t4_frame2", frame_at(1), 16'h8100);
`endif
        chk("t4_underrun_set", underrun, 1);
        underrun_clr = 1'b1;
        @(negedge clk);
        #1;
        underrun_clr = 1'b0;
        chk("t4_underrun_clr", underrun, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("t4_underrun_hold", underrun, 0);
        c = 0;
        while (!underrun && c < 120) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("t4_underrun_reset_by_tick", underrun, 1);

        // Reset asserted at the 7th SCLK rise of the frame in flight.
        c = 0;
        while (!(mon_active && mon_nbits == 7) && c < 200) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("t5_reached_rise7", mon_nbits, 7);
        reset = 1'b0;
        #1;
        chk("t5_cs_n", dac_cs_n, 1);
        chk("t5_sclk", dac_sclk, 0);
        chk("t5_mosi", dac_mosi, 0);
        chk("t5_level", fifo_level, 0);
        do_reset();
        wait_frames(1, 300);
        chk("t5_frame", frame_at(0), 16'h8000);
        chk("t5_underrun", underrun, 1);

        // Randomized traffic at several fill rates.
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            for (int k = 0; k < 500; k++) begin
                s_valid      = ($urandom_range(0, 999) < rates[seg % 4]);
                s_data       = $urandom;
                underrun_clr = ($urandom_range(0, 63) == 0);
                @(negedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        underrun_clr = 1'b0;
        repeat (200) @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
